// File: rtl/rgmii_rx_nibble_adapter.sv
// RGMII RX nibble adapter: 1G byte pass-through or 10/100 nibble-to-byte packing with a byte strobe.
// Latency: 1 cycle from a 1G byte, or from the high nibble at 10/100, to m_rxd/m_rx_clk_en.
// Backpressure: none. The MAC samples m_* only while m_rx_clk_en=1.
//
// Ports:
//   clk, rst                     RX clock (gmii_rx_clk); asynchronous active-high reset
//   gmii_rxd/rx_dv/rx_er         RX stream from the RGMII PHY interface ([3:0] only at 10/100)
//   cfg_speed                    configured speed: 10=1G, 01=100M, 00=10M, 11 handled as 1G
//   m_rxd/m_rx_dv/m_rx_er        byte stream to the GMII RX MAC
//   m_rx_clk_en                  byte strobe for the MAC
//   speed                        effective speed in use
//   link_up/full_duplex          decoded in-band status
//   frame_odd                    one-cycle pulse when a frame ends on an unpaired nibble
// Optional feature: define RGMII_RX_INBAND_STATUS_EN to decode in-band link status from the
// inter-frame period and use it to select the speed. Without it, link_up=full_duplex=0 and
// speed follows cfg_speed.
module rgmii_rx_nibble_adapter #(
  parameter int STATUS_STABLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [1:0] cfg_speed,
  output logic [7:0] m_rxd,
  output logic       m_rx_dv,
  output logic       m_rx_er,
  output logic       m_rx_clk_en,
  output logic [1:0] speed,
  output logic       link_up,
  output logic       full_duplex,
  output logic       frame_odd
);

  generate
    if (STATUS_STABLE < 1 || STATUS_STABLE > 15) begin : g_bad_status_stable
      $error("STATUS_STABLE must be in the range 1..15");
    end
  endgenerate

  typedef enum logic {PH_LOW = 1'b0, PH_HIGH = 1'b1} phase_t;

  phase_t     state, state_n;
  logic       in_frame, in_frame_n;   // frame seen, end-of-frame strobe still owed
  logic       idle_tgl, idle_tgl_n;   // divides the idle strobe down to every other cycle
  logic [3:0] nib_lo, nib_lo_n;
  logic       er_acc, er_acc_n;
  logic [7:0] rxd_n;
  logic       dv_n, er_n, en_n, odd_n;
  logic [1:0] eff;
  logic [1:0] speed_q;
  logic       hold;
  logic       gig, gig_q;

`ifdef RGMII_RX_INBAND_STATUS_EN
  localparam logic [3:0] STABLE_CNT = 4'(STATUS_STABLE);

  logic       st_sample;
  logic [3:0] st_samp;                // {duplex, speed[1:0], link}
  logic [3:0] st_last;
  logic [3:0] st_cnt, st_cnt_n;
  logic [1:0] st_speed;
  logic       link_q, fdx_q;

  // Carrier extend / false carrier (er=1 while dv=0) is not status: the count holds.
  assign st_sample = !gmii_rx_dv && !gmii_rx_er;
  assign st_samp   = gmii_rxd[3:0];

  always_comb begin
    st_cnt_n = st_cnt;
    if (st_sample) begin
      if (st_samp != st_last) begin
        st_cnt_n = 4'd1;
      end else if (st_cnt != 4'hF) begin
        st_cnt_n = st_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_last  <= 4'h0;
      st_cnt   <= 4'h0;
      st_speed <= 2'b00;
      link_q   <= 1'b0;
      fdx_q    <= 1'b0;
    end else if (st_sample) begin
      st_last <= st_samp;
      st_cnt  <= st_cnt_n;
      if (st_cnt_n >= STABLE_CNT) begin
        link_q   <= st_samp[0];
        st_speed <= st_samp[2:1];
        fdx_q    <= st_samp[3];
      end
    end
  end

  assign eff         = link_q ? st_speed : cfg_speed;
  assign link_up     = link_q;
  assign full_duplex = fdx_q;
`else
  assign eff         = cfg_speed;
  assign link_up     = 1'b0;
  assign full_duplex = 1'b0;
`endif

  // Speed is frozen while a frame is on the wire or its end strobe is still owed, so a
  // configuration or status change mid-frame only lands once the frame has closed.
  assign hold  = in_frame || gmii_rx_dv;
  assign speed = hold ? speed_q : eff;
  assign gig   = speed[1];
  assign gig_q = speed_q[1];

  always_comb begin
    state_n    = state;
    in_frame_n = in_frame;
    idle_tgl_n = 1'b0;
    nib_lo_n   = nib_lo;
    er_acc_n   = er_acc;
    rxd_n      = m_rxd;
    dv_n       = m_rx_dv;
    er_n       = m_rx_er;
    en_n       = 1'b0;
    odd_n      = 1'b0;

    if (gig) begin
      state_n    = PH_LOW;
      in_frame_n = gmii_rx_dv;
      rxd_n      = gmii_rxd;
      dv_n       = gmii_rx_dv;
      er_n       = gmii_rx_er;
      en_n       = 1'b1;
    end else if (gig_q) begin
      // Just left 1G (only possible in idle): start the nibble pipeline from a clean slate.
      state_n    = PH_LOW;
      in_frame_n = 1'b0;
      nib_lo_n   = 4'h0;
      er_acc_n   = 1'b0;
      rxd_n      = 8'h00;
      dv_n       = 1'b0;
      er_n       = 1'b0;
    end else begin
      case (state)
        PH_LOW: begin
          if (gmii_rx_dv) begin
            nib_lo_n   = gmii_rxd[3:0];
            er_acc_n   = gmii_rx_er;
            in_frame_n = 1'b1;
            state_n    = PH_HIGH;
          end else if (in_frame) begin
            // End-of-frame strobe: the MAC needs one clocked dv=0 to close the frame.
            rxd_n      = 8'h00;
            dv_n       = 1'b0;
            er_n       = 1'b0;
            en_n       = 1'b1;
            in_frame_n = 1'b0;
          end else begin
            idle_tgl_n = !idle_tgl;
            en_n       = idle_tgl;
            if (idle_tgl) begin
              rxd_n = 8'h00;
              dv_n  = 1'b0;
              er_n  = 1'b0;
            end
          end
        end
        PH_HIGH: begin
          state_n = PH_LOW;
          en_n    = 1'b1;
          dv_n    = 1'b1;
          if (gmii_rx_dv) begin
            rxd_n = {gmii_rxd[3:0], nib_lo};
            er_n  = er_acc || gmii_rx_er;
          end else begin
            // Unpaired nibble: flush it flagged as errored; in_frame stays set so the end
            // strobe follows on the next cycle.
            rxd_n = {4'h0, nib_lo};
            er_n  = 1'b1;
            odd_n = 1'b1;
          end
        end
        default: state_n = PH_LOW;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PH_LOW;
      in_frame    <= 1'b0;
      idle_tgl    <= 1'b0;
      nib_lo      <= 4'h0;
      er_acc      <= 1'b0;
      speed_q     <= 2'b10;
      m_rxd       <= 8'h00;
      m_rx_dv     <= 1'b0;
      m_rx_er     <= 1'b0;
      m_rx_clk_en <= 1'b0;
      frame_odd   <= 1'b0;
    end else begin
      state       <= state_n;
      in_frame    <= in_frame_n;
      idle_tgl    <= idle_tgl_n;
      nib_lo      <= nib_lo_n;
      er_acc      <= er_acc_n;
      speed_q     <= speed;
      m_rxd       <= rxd_n;
      m_rx_dv     <= dv_n;
      m_rx_er     <= er_n;
      m_rx_clk_en <= en_n;
      frame_odd   <= odd_n;
    end
  end

endmodule

// File: doc/rgmii_rx_nibble_adapter.md
Name: rgmii_rx_nibble_adapter

Overview:
- Sits directly downstream of the RGMII PHY interface RX path, in the gmii_rx_clk domain, ahead of the GMII RX MAC.
- At 1000M, passes bytes through with one register stage.
- At 10M/100M, packs consecutive low-nibble samples into bytes and produces a byte strobe (clock enable) for the MAC.
- Optionally decodes RGMII in-band link status from the inter-frame period and uses it to select the effective speed.

Parameters:
- STATUS_STABLE, default 4: consecutive identical in-band status samples required before status outputs update. Range 1..15.

Ports:
- clk  in  1  RX clock (gmii_rx_clk from PHY interface)
- rst  in  1  reset, asynchronous, active-high
- gmii_rxd  in  8  RX data from PHY interface; only [3:0] meaningful at 10/100
- gmii_rx_dv  in  1  RX data valid
- gmii_rx_er  in  1  RX error
- cfg_speed  in  2  configured speed: 2'b10 1G, 2'b01 100M, 2'b00 10M; 2'b11 treated as 1G
- m_rxd  out  8  assembled byte to MAC
- m_rx_dv  out  1  data valid to MAC
- m_rx_er  out  1  error to MAC
- m_rx_clk_en  out  1  byte strobe; MAC samples m_* only when high
- speed  out  2  effective speed in use
- link_up  out  1  in-band link status
- full_duplex  out  1  in-band duplex status
- frame_odd  out  1  one-cycle pulse: frame ended on an unpaired nibble

Behaviour:
- Reset (async assert, sync release): m_rxd=0, m_rx_dv=0, m_rx_er=0, m_rx_clk_en=0, frame_odd=0, link_up=0, full_duplex=0, speed=cfg_speed, phase=0, status counter=0.
- Effective speed (eff) is re-evaluated only while gmii_rx_dv=0 and no frame is in progress. A change of cfg_speed or decoded status during a frame takes effect after the frame ends.
- 1G mode (eff=2'b10):
  - Every cycle: m_rxd<=gmii_rxd, m_rx_dv<=gmii_rx_dv, m_rx_er<=gmii_rx_er, m_rx_clk_en<=1.
  - Latency 1 cycle.
- 10/100 mode: two-state machine with a phase bit.
  - LOW: on gmii_rx_dv=1, latch nibble L=gmii_rxd[3:0] and er_acc=gmii_rx_er, move to HIGH. m_rx_clk_en<=0.
  - HIGH, gmii_rx_dv=1: emit m_rxd<={gmii_rxd[3:0],L}, m_rx_dv<=1, m_rx_er<=er_acc|gmii_rx_er, m_rx_clk_en<=1, return to LOW. Byte latency is 1 cycle after the high nibble.
  - HIGH, gmii_rx_dv=0 (odd nibble count): emit m_rxd<={4'h0,L}, m_rx_dv<=1, m_rx_er<=1, m_rx_clk_en<=1, pulse frame_odd, go to LOW.
  - Frame end: on the first cycle gmii_rx_dv=0 in LOW after a frame, emit one strobe with m_rx_dv=0, m_rx_er=0 so the MAC sees end of frame. The odd-nibble case emits this end strobe on the following cycle.
  - Idle (gmii_rx_dv=0, no frame end pending): m_rx_clk_en pulses once every 2 cycles with m_rx_dv=0. This keeps the MAC clocked.
  - The first nibble after a gmii_rx_dv rise is always the low nibble; phase is forced to LOW whenever gmii_rx_dv=0.
- Mode switch: occurs only in idle; the pipeline and phase are cleared on a switch, and no partial byte is emitted.
- rst mid-frame: outputs return to reset values at once. The next frame restarts phase at LOW.

Optional Feature:
- Macro: RGMII_RX_INBAND_STATUS_EN.
- Defined, status sampling: when gmii_rx_dv=0 and gmii_rx_er=0, sample s={gmii_rxd[3],gmii_rxd[2:1],gmii_rxd[0]} = {duplex, speed, link}.
- Defined, counter: counts consecutive equal samples; it resets to 1 on a differing sample and holds while gmii_rx_dv=1 or gmii_rx_er=1 (carrier extend / false carrier are not status).
- Defined, update: when the count reaches STATUS_STABLE, link_up, full_duplex and the decoded speed update.
- Defined, speed selection: eff = decoded speed while link_up=1, else cfg_speed.
- Not defined: link_up=0, full_duplex=0, eff=cfg_speed always, and no status logic is generated.

Test Plan:
- 1G: cfg_speed=2'b10; drive bytes 0x55 x7, 0xD5, 0x01, 0x02 with dv=1. Required: identical bytes on m_rxd one cycle later, m_rx_clk_en=1 every cycle, m_rx_er=0.
- 100M even frame: cfg_speed=2'b01; nibbles 5,5,...,5,D,1,0,2,0. Required: strobed bytes 0x55..,0xD5,0x01,0x02, strobes every 2nd cycle, then one strobe with m_rx_dv=0.
- 10M odd frame: cfg_speed=2'b00; nibbles 5,D,7 then dv=0. Required: byte 0xD5, then 0x07 with m_rx_er=1 and frame_odd pulse, then an end strobe with m_rx_dv=0.
- Error merge: 100M, gmii_rx_er=1 on the low nibble only of byte 0x3A. Required: m_rxd=0x3A with m_rx_er=1; adjacent bytes have er=0.
- In-band status (macro defined, STATUS_STABLE=4): idle rxd=4'hD (duplex=1, speed=2'b10, link=1) for 3 cycles. Required: no update after 3 cycles; after the 4th cycle link_up=1, full_duplex=1, speed=2'b10. A 0x0E sample with er=1 in between neither resets nor advances the count.
- Reset mid-frame: assert rst during a 100M frame after a low nibble. Required: all outputs are 0 immediately; after release, the next frame 5,D yields 0xD5 correctly aligned.
